// File: rtl/fan_pkg.sv
// Shared definitions for the fan tachometer measurement path.
//   fan_state_e : measurement FSM encoding (SYNC, MEASURE)
//   all_ones()  : saturation value for a counter of a given width
package fan_pkg;

  typedef enum logic {
    SYNC    = 1'b0,
    MEASURE = 1'b1
  } fan_state_e;

  // Computed in 64 bits so that a 32-bit counter still gets a correct value.
  function automatic logic [63:0] all_ones(input int unsigned width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/fan_tach_meter_filter.sv
// tach_filter: front end for the raw open-drain tach signal.
//   clk, rst_n : system clock, async active-low reset
//   tach_i     : raw tach, asynchronous to clk
//   level_o    : de-glitched tach level
//   rise_o     : one-cycle pulse on each filtered 0->1 transition
// The level only changes after FILT_LEN consecutive synchronised samples
// disagree with it, so a clean rise reaches rise_o 2+FILT_LEN clocks later.
module tach_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tach_i,
  output logic level_o,
  output logic rise_o
);

  localparam int FW = $clog2(FILT_LEN + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [FW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] cnt_inc;

  always_comb begin
    sync1_d = tach_i;
    sync2_d = sync1_q;
    cnt_inc = cnt_q + FW'(1);
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_inc == FW'(FILT_LEN)) begin
        // Level accepted; counter restarts from zero for the next change.
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/fan_tach_meter.sv
// fan_tach_meter: measures the fan revolution period in prescaled ticks.
//   clk, rst_n : system clock, async active-low reset
//   en_i       : measurement enable; low parks the FSM in SYNC
//   tach_i     : raw tach input from the pad
//   period_o   : ticks per revolution of the last completed measurement,
//                all-ones after a stall
//   valid_o    : one-cycle strobe whenever period_o is written
//   stall_o    : high while no revolution has completed within the timeout
//
// state   | meaning
// --------+-----------------------------------------------------------------
// SYNC    | waiting for a filtered tach edge to start counting; counters at 0
// MEASURE | counting ticks and edges; publishes a period every revolution
module fan_tach_meter
  import fan_pkg::*;
#(
  parameter int CLK_DIV        = 64,
  parameter int FILT_LEN       = 4,
  parameter int PULSES_PER_REV = 2,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             tach_i,
  output logic [CNT_W-1:0] period_o,
  output logic             valid_o,
  output logic             stall_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EW = (PULSES_PER_REV > 1) ? $clog2(PULSES_PER_REV) : 1;
  localparam logic [CNT_W-1:0] SAT = CNT_W'(all_ones(CNT_W));

  logic             rise;

  fan_state_e       state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [EW-1:0]    edge_q, edge_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             stall_q, stall_d;

  logic             tick;
  logic [CNT_W-1:0] cnt_inc;
  logic             rev_done;

  tach_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .tach_i  (tach_i),
    .level_o (),
    .rise_o  (rise)
  );

  // Free-running prescaler; never realigned to tach edges.
  always_comb begin
    tick  = (div_q == DW'(CLK_DIV - 1));
    div_d = tick ? '0 : div_q + DW'(1);
  end

  always_comb begin
    // Tick in the same cycle as a completing edge is still counted.
    cnt_inc = cnt_q;
    if (tick && (cnt_q != SAT)) begin
      cnt_inc = cnt_q + CNT_W'(1);
    end
    rev_done = rise && (edge_q == EW'(PULSES_PER_REV - 1));

    state_d  = state_q;
    cnt_d    = '0;
    edge_d   = '0;
    period_d = period_q;
    valid_d  = 1'b0;
    stall_d  = stall_q;

    if (!en_i) begin
      state_d = SYNC;
    end else begin
      case (state_q)
        SYNC: begin
          if (rise) begin
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          // Completion has priority over a timeout in the same cycle.
          if (rev_done) begin
            period_d = cnt_inc;
            valid_d  = 1'b1;
            stall_d  = 1'b0;
          end else if (cnt_q == SAT) begin
            period_d = SAT;
            valid_d  = 1'b1;
            stall_d  = 1'b1;
            state_d  = SYNC;
          end else begin
            cnt_d  = cnt_inc;
            edge_d = rise ? edge_q + EW'(1) : edge_q;
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SYNC;
      div_q    <= '0;
      cnt_q    <= '0;
      edge_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      stall_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      edge_q   <= edge_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      stall_q  <= stall_d;
    end
  end

  assign period_o = period_q;
  assign valid_o  = valid_q;
  assign stall_o  = stall_q;

endmodule

// File: tb/tb_fan_tach_meter.sv
module tb_fan_tach_meter;

  localparam int CLK_DIV  = 4;
  localparam int FILT_LEN = 2;
  localparam int PPR      = 2;
  localparam int CNT_W    = 8;
  localparam int SATV     = 255;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic             en_i   = 1'b1;
  logic             tach_i = 1'b0;
  logic [CNT_W-1:0] period_o;
  logic             valid_o;
  logic             stall_o;

  always #5 clk = ~clk;

  fan_tach_meter #(
    .CLK_DIV        (CLK_DIV),
    .FILT_LEN       (FILT_LEN),
    .PULSES_PER_REV (PPR),
    .CNT_W          (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (en_i),
    .tach_i   (tach_i),
    .period_o (period_o),
    .valid_o  (valid_o),
    .stall_o  (stall_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s got %0d want %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s got %0d want %0d..%0d at t=%0t", nm, act, lo, hi, $time);
    end
  endtask

  // Reference model: works on cycle stamps since reset release. A tick
  // happens in every cycle c with c % CLK_DIV == CLK_DIV-1; a measurement
  // between two edge events at cycles a and b is the number of ticks in (a,b].
  bit ring [16];
  bit m_lvl, m_meas;
  int m_s, m_n, m_c;
  bit exp_valid, exp_stall;
  int exp_period;
  int vcount;

  function automatic int ticks(input int a, input int b);
    return (b + 1) / CLK_DIV - (a + 1) / CLK_DIV;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) ring[i] = 1'b0;
    m_lvl = 1'b0;
    m_meas = 1'b0;
    m_s = 0;
    m_n = 0;
    m_c = 0;
    exp_valid = 1'b0;
    exp_stall = 1'b1;
    exp_period = 0;
  endtask

  always @(negedge clk) begin
    bit flip, ev, nv;
    int t;
    if (!rst_n) begin
      chk("rst_period", int'(period_o), 0);
      chk("rst_valid", int'(valid_o), 0);
      chk("rst_stall", int'(stall_o), 1);
      model_reset();
    end else begin
      chk("valid", int'(valid_o), int'(exp_valid));
      chk("stall", int'(stall_o), int'(exp_stall));
      chk("period", int'(period_o), exp_period);
      if (valid_o) vcount++;

      // Filter: the synchronised sample seen in cycle c is tach from cycle
      // c-2; the level changes once FILT_LEN such samples all disagree.
      ring[m_c % 16] = tach_i;
      flip = 1'b1;
      for (int i = 1; i <= FILT_LEN; i++) begin
        if (ring[(m_c - 2 - i + 16) % 16] == m_lvl) flip = 1'b0;
      end
      ev = 1'b0;
      if (flip) begin
        m_lvl = !m_lvl;
        ev = m_lvl;
      end

      nv = 1'b0;
      if (!en_i) begin
        m_meas = 1'b0;
      end else if (m_meas) begin
        if (ev && m_n == PPR - 1) begin
          t = ticks(m_s, m_c);
          nv = 1'b1;
          exp_period = (t > SATV) ? SATV : t;
          exp_stall = 1'b0;
          m_s = m_c;
          m_n = 0;
        end else if (ticks(m_s, m_c - 1) >= SATV) begin
          nv = 1'b1;
          exp_period = SATV;
          exp_stall = 1'b1;
          m_meas = 1'b0;
        end else if (ev) begin
          m_n++;
        end
      end else if (ev) begin
        m_meas = 1'b1;
        m_s = m_c;
        m_n = 0;
      end
      exp_valid = nv;
      m_c++;
    end
  end

  // half == 0 holds tach low; start lets a wave continue across calls.
  task automatic run_wave(input int half, input bit glitch, input int cycles, input int start);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (half == 0) begin
        tach_i = 1'b0;
      end else begin
        int ph;
        ph = (start + i) % (2 * half);
        tach_i = (ph >= half);
        if (glitch && ph == half / 2) tach_i = 1'b1;
      end
    end
  endtask

  typedef struct {
    string name;
    int    half;
    bit    glitch;
    bit    en;
    int    cycles;
    int    vmin;
    int    vmax;
    int    pmin;
    int    pmax;
    int    stall_end;
  } scen_t;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    scen_t tbl [6];
    tbl[0] = '{"steady",   200, 1'b0, 1'b1, 4000, 4, 5, 199, 201, 0};
    tbl[1] = '{"glitch",   200, 1'b1, 1'b1, 4000, 4, 5, 199, 201, 0};
    tbl[2] = '{"stall",      0, 1'b0, 1'b1, 1500, 1, 1, 255, 255, 1};
    tbl[3] = '{"recover",  200, 1'b0, 1'b1, 2000, 2, 2, 199, 201, 0};
    tbl[4] = '{"en_off",   200, 1'b0, 1'b0, 1000, 0, 0, 199, 201, 0};
    tbl[5] = '{"en_on",    200, 1'b0, 1'b1, 1600, 1, 1, 199, 201, 0};

    vcount = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int r = 0; r < 6; r++) begin
      en_i = tbl[r].en;
      vcount = 0;
      run_wave(tbl[r].half, tbl[r].glitch, tbl[r].cycles, 0);
      @(negedge clk);
      #1;
      chk_rng({tbl[r].name, "_valid_count"}, vcount, tbl[r].vmin, tbl[r].vmax);
      chk_rng({tbl[r].name, "_period"}, int'(period_o), tbl[r].pmin, tbl[r].pmax);
      chk({tbl[r].name, "_stall"}, int'(stall_o), tbl[r].stall_end);
    end

    // Reset in the middle of a revolution, asserted between clock edges.
    en_i = 1'b1;
    run_wave(200, 1'b0, 500, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_period", int'(period_o), 0);
    chk("async_rst_valid", int'(valid_o), 0);
    chk("async_rst_stall", int'(stall_o), 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    vcount = 0;
    run_wave(200, 1'b0, 1000, 0);
    @(negedge clk);
    #1;
    chk("post_rst_two_edges_no_valid", vcount, 0);
    vcount = 0;
    run_wave(200, 1'b0, 200, 1000);
    @(negedge clk);
    #1;
    chk("post_rst_third_edge_valid", vcount, 1);
    chk_rng("post_rst_period", int'(period_o), 199, 201);
    chk("post_rst_stall", int'(stall_o), 0);

    // Random segments, checked cycle by cycle against the model.
    for (int k = 0; k < 10; k++) begin
      int h, n;
      bit g;
      h = int'($urandom_range(300, 30));
      n = int'($urandom_range(2000, 400));
      g = 1'($urandom_range(1, 0));
      en_i = ($urandom_range(4, 0) != 0);
      run_wave(h, g, n, 0);
    end

    en_i = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
